// File: rtl/ex_stage_pipe.sv
// Execute stage: forwarding muxes, single-cycle ALU, branch-target adder and an
// optional shift-add multiplier, feeding a valid/ready registered EX/MEM output.
module ex_stage_pipe #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned MUL_EN = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      alu_op,
  input  logic [3:0]      funct,
  input  logic            alu_src,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic [1:0]      fwd_a,
  input  logic [1:0]      fwd_b,
  input  logic [XLEN-1:0] wb_fwd_data,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [XLEN-1:0] out_branch_target,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_zero,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [SHW-1:0]    cnt_q;
  logic [XLEN-1:0]   mcand_q, mplier_q, acc_q;
  logic [XLEN-1:0]   m_store_q, m_br_q;
  logic [4:0]        m_rd_q;
  logic              m_rw_q;

  logic              out_valid_q, out_rw_q;
  logic [XLEN-1:0]   out_result_q, out_store_q, out_br_q;
  logic [4:0]        out_rd_q;

  logic [XLEN-1:0]   op_a, op_b_fwd, alu_b, alu_res, br_target;
  logic [SHW-1:0]    shamt;
  logic              is_mul, xfer, out_free;

  // Forwarding muxes; code 11 falls back to register data
  always_comb begin
    op_a = rs1_data;
    case (fwd_a)
      2'b01:   op_a = wb_fwd_data;
      2'b10:   op_a = mem_fwd_data;
      default: op_a = rs1_data;
    endcase
    op_b_fwd = rs2_data;
    case (fwd_b)
      2'b01:   op_b_fwd = wb_fwd_data;
      2'b10:   op_b_fwd = mem_fwd_data;
      default: op_b_fwd = rs2_data;
    endcase
  end

  assign alu_b     = alu_src ? imm : op_b_fwd;
  assign shamt     = alu_b[SHW-1:0];
  assign br_target = pc + (imm << 1);

  // ALU; unrecognised decode codes and a disabled multiplier both fall back to add
  always_comb begin
    alu_res = op_a + alu_b;
    case (alu_op)
      2'b01: alu_res = op_a - alu_b;
      2'b10: begin
        case (funct)
          4'b1000: alu_res = op_a - alu_b;
          4'b0111: alu_res = op_a & alu_b;
          4'b0110: alu_res = op_a | alu_b;
          4'b0100: alu_res = op_a ^ alu_b;
          4'b0001: alu_res = op_a << shamt;
          4'b0101: alu_res = op_a >> shamt;
          4'b1101: alu_res = XLEN'($signed(op_a) >>> shamt);
          4'b0010: alu_res = XLEN'($signed(op_a) < $signed(alu_b));
          4'b0011: alu_res = XLEN'(op_a < alu_b);
          default: alu_res = op_a + alu_b;
        endcase
      end
      default: alu_res = op_a + alu_b;
    endcase
  end

  assign is_mul   = (alu_op == 2'b11) && (MUL_EN != 0);
  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == S_IDLE) && out_free && !flush;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (xfer && is_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == SHW'(XLEN - 1)) state_d = S_DONE;
      S_DONE:  if (out_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Shift-add multiplier; operands and sideband are captured at transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      m_store_q <= '0;
      m_br_q    <= '0;
      m_rd_q    <= '0;
      m_rw_q    <= 1'b0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (xfer && is_mul) begin
        cnt_q     <= '0;
        mcand_q   <= op_a;
        mplier_q  <= alu_b;
        acc_q     <= '0;
        m_store_q <= op_b_fwd;
        m_br_q    <= br_target;
        m_rd_q    <= rd;
        m_rw_q    <= reg_write;
      end
    end else if (state_q == S_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + SHW'(1);
    end
  end

  // EX/MEM output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_store_q  <= '0;
      out_br_q     <= '0;
      out_rd_q     <= '0;
      out_rw_q     <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (xfer && !is_mul) begin
      out_valid_q  <= 1'b1;
      out_result_q <= alu_res;
      out_store_q  <= op_b_fwd;
      out_br_q     <= br_target;
      out_rd_q     <= rd;
      out_rw_q     <= reg_write;
    end else if ((state_q == S_DONE) && out_free) begin
      out_valid_q  <= 1'b1;
      out_result_q <= acc_q;
      out_store_q  <= m_store_q;
      out_br_q     <= m_br_q;
      out_rd_q     <= m_rd_q;
      out_rw_q     <= m_rw_q;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_result        = out_result_q;
  assign out_store_data    = out_store_q;
  assign out_branch_target = out_br_q;
  assign out_rd            = out_rd_q;
  assign out_reg_write     = out_rw_q;
  assign out_zero          = (out_result_q == '0);

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe (XLEN=64): ALU decode, forwarding, handshake,
// multiplier latency, flush and mid-multiply reset; a MUL_EN=0 twin checks fallback.
module tb_ex_stage_pipe;

  localparam logic [63:0] ALL_F = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, reset;
  logic        in_valid, in_ready;
  logic [63:0] rs1_data, rs2_data, imm, pc;
  logic [1:0]  alu_op;
  logic [3:0]  funct;
  logic        alu_src;
  logic [4:0]  rd;
  logic        reg_write;
  logic [1:0]  fwd_a, fwd_b;
  logic [63:0] wb_fwd_data, mem_fwd_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result, out_store_data, out_branch_target;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_zero, busy;

  logic        nm_in_ready, nm_out_valid, nm_out_reg_write, nm_out_zero, nm_busy;
  logic [63:0] nm_out_result, nm_out_store_data, nm_out_branch_target;
  logic [4:0]  nm_out_rd;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage_pipe #(.XLEN(64), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rd(rd), .reg_write(reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_fwd_data(wb_fwd_data), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_branch_target(out_branch_target),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_zero(out_zero), .busy(busy)
  );

  ex_stage_pipe #(.XLEN(64), .MUL_EN(0)) u_nomul (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nm_in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_op(alu_op), .funct(funct), .alu_src(alu_src), .rd(rd), .reg_write(reg_write),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_fwd_data(wb_fwd_data), .mem_fwd_data(mem_fwd_data),
    .flush(flush), .out_valid(nm_out_valid), .out_ready(out_ready), .out_result(nm_out_result),
    .out_store_data(nm_out_store_data), .out_branch_target(nm_out_branch_target),
    .out_rd(nm_out_rd), .out_reg_write(nm_out_reg_write), .out_zero(nm_out_zero), .busy(nm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decode vectors: funct, rs1, rs2, expected result
  logic [3:0]  v_funct [10] = '{4'b0111, 4'b0110, 4'b0100, 4'b0001, 4'b0101,
                                4'b1101, 4'b0010, 4'b0011, 4'b1111, 4'b0000};
  logic [63:0] v_a [10] = '{64'hF0F0, 64'hF0F0, 64'hF0F0, 64'h1, 64'h8000_0000_0000_0000,
                            64'h8000_0000_0000_0000, ALL_F, ALL_F, 64'h2, ALL_F};
  logic [63:0] v_b [10] = '{64'hFF00, 64'hFF00, 64'hFF00, 64'h43, 64'h4,
                            64'h41, 64'h1, 64'h1, 64'h3, 64'h1};
  logic [63:0] v_exp [10] = '{64'hF000, 64'hFFF0, 64'h0FF0, 64'h8, 64'h0800_0000_0000_0000,
                              64'hC000_0000_0000_0000, 64'h1, 64'h0, 64'h5, 64'h0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [3:0] f,
                        input logic [63:0] a, input logic [63:0] b);
    alu_op = op; funct = f; rs1_data = a; rs2_data = b;
    fwd_a = 2'b00; fwd_b = 2'b00; alu_src = 1'b0; imm = '0; pc = '0;
  endtask

  initial begin
    int n;
    int seen;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    rd = '0; reg_write = 1'b0; wb_fwd_data = '0; mem_fwd_data = '0;
    set_op(2'b00, 4'b0000, '0, '0);
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", out_result, 64'd0);
    check("rst_out_store", out_store_data, 64'd0);
    check("rst_out_branch", out_branch_target, 64'd0);
    check("rst_out_rd", 64'(out_rd), 64'd0);
    check("rst_out_rw", 64'(out_reg_write), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_zero", 64'(out_zero), 64'd1);
    #10 reset = 1'b1;
    cycle();

    // Decoded sub 5-7 with latency 1
    set_op(2'b10, 4'b1000, 64'd5, 64'd7);
    rd = 5'd3; reg_write = 1'b1; in_valid = 1'b1;
    #1 check("sub_in_ready", 64'(in_ready), 64'd1);
    cycle();
    check("sub_valid", 64'(out_valid), 64'd1);
    check("sub_result", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub_zero", 64'(out_zero), 64'd0);
    check("sub_rd", 64'(out_rd), 64'd3);
    check("sub_rw", 64'(out_reg_write), 64'd1);
    check("sub_store", out_store_data, 64'd7);

    // Forwarded A plus immediate, branch target
    set_op(2'b00, 4'b0000, 64'h55, 64'h55);
    fwd_a = 2'b10; mem_fwd_data = 64'h10; alu_src = 1'b1; imm = 64'h4; pc = 64'h100;
    fwd_b = 2'b01; wb_fwd_data = 64'h99;
    cycle();
    check("fwd_result", out_result, 64'h14);
    check("fwd_branch", out_branch_target, 64'h108);
    check("fwd_store", out_store_data, 64'h99);

    for (int i = 0; i < 10; i++) begin
      set_op(2'b10, v_funct[i], v_a[i], v_b[i]);
      cycle();
      check($sformatf("dec%0d_result", i), out_result, v_exp[i]);
      check($sformatf("dec%0d_zero", i), 64'(out_zero), 64'(v_exp[i] == 64'd0));
    end
    in_valid = 1'b0;
    cycle();
    check("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure holds output and blocks input
    out_ready = 1'b0;
    set_op(2'b00, 4'b0000, 64'd1, 64'd2);
    in_valid = 1'b1;
    cycle();
    check("bp_first", out_result, 64'd3);
    set_op(2'b00, 4'b0000, 64'd10, 64'd20);
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
      cycle();
      check($sformatf("bp_hold%0d", i), out_result, 64'd3);
      check($sformatf("bp_valid%0d", i), 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready), 64'd1);
    cycle();
    check("bp_next", out_result, 64'd30);
    in_valid = 1'b0;
    cycle();

    // Multiply: latency XLEN+2, operands latched at transfer
    set_op(2'b11, 4'b0000, 64'h1234, 64'h10);
    rd = 5'd9; in_valid = 1'b1;
    #1 check("mul_in_ready", 64'(in_ready), 64'd1);
    cycle();
    in_valid = 1'b0; fwd_a = 2'b01; wb_fwd_data = 64'hDEAD; rs1_data = 64'h7777;
    #1;
    check("mul_busy", 64'(busy), 64'd1);
    check("mul_block", 64'(in_ready), 64'd0);
    check("nomul_valid", 64'(nm_out_valid), 64'd1);
    check("nomul_add", nm_out_result, 64'h1244);
    n = 1;
    while (!out_valid && n < 100) begin
      cycle();
      n++;
    end
    check("mul_latency", 64'(n), 64'd66);
    check("mul_result", out_result, 64'h12340);
    check("mul_rd", 64'(out_rd), 64'd9);
    check("mul_done_busy", 64'(busy), 64'd0);
    cycle();
    check("mul_drain", 64'(out_valid), 64'd0);

    // Flush at multiply cycle 10, concurrent bundle dropped
    set_op(2'b11, 4'b0000, 64'd3, 64'd5);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (9) cycle();
    set_op(2'b00, 4'b0000, 64'd1, 64'd1);
    in_valid = 1'b1; flush = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    seen = 0;
    repeat (80) begin
      cycle();
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);

    // Reset at cycle 20 of a second multiply
    set_op(2'b11, 4'b0000, 64'd7, 64'd9);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (19) cycle();
    reset = 1'b0;
    #1;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_result", out_result, 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_rd", 64'(out_rd), 64'd0);
    #2 reset = 1'b1;
    seen = 0;
    repeat (80) begin
      cycle();
      if (out_valid) seen++;
    end
    check("mrst_no_valid", 64'(seen), 64'd0);

    set_op(2'b00, 4'b0000, 64'd5, 64'd6);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    check("post_rst_result", out_result, 64'd11);
    check("post_rst_valid", 64'(out_valid), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
